dsa_csr_bank: RTL

Parametrised single-clock control/status register bank for the bilinear DSA core. It sits on the system side after the JTAG-to-system clock-domain crossing. It accepts already-synchronised read/write requests over a valid/ready handshake and drives N configuration words, a width-programmable start pulse and a sticky-done interrupt. It adds behaviour the previous bank lacked: read responses with error flag, busy-guarded start, write-1-to-clear status, and an optional busy-cycle performance counter.

---
 rtl/dsa_csr_bank.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/dsa_csr_bank.sv
// rtl/dsa_csr_bank.sv - DSA control/status register bank; DSA_CSR_PERF_EN adds the busy-cycle PERF counter
module dsa_csr_bank #(
    parameter int                      ADDR_W      = 8,
    parameter int                      DATA_W      = 32,
    parameter int                      N_CFG       = 4,
    parameter int                      START_W     = 8,
    parameter logic [N_CFG*DATA_W-1:0] CFG_RST_VAL = '0
) (
    input  logic                    clk_sys,
    input  logic                    rst_sys_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W-1:0]       req_wdata,
    output logic                    rsp_valid,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_err,
    output logic [N_CFG*DATA_W-1:0] cfg_flat,
    output logic                    start_pulse,
    input  logic                    core_busy,
    input  logic                    core_done,
    output logic                    irq
);

    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(32'h00);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(32'h10);
    localparam logic [ADDR_W-1:0] A_PERF   = ADDR_W'(32'h11);
    localparam logic [31:0]       DEAD     = 32'hDEADBEEF;
    localparam logic [DATA_W-1:0] BAD_DATA = DATA_W'(DEAD);
    localparam logic [7:0]        START_LD = 8'(START_W);

    typedef enum logic {S_IDLE, S_RESP} state_t;

    state_t                         state_q, state_d;
    logic                           req_ready_q, req_ready_d;
    logic                           rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]              rsp_rdata_q, rsp_rdata_d;
    logic                           rsp_err_q, rsp_err_d;
    logic [N_CFG-1:0][DATA_W-1:0]   cfg_q, cfg_d;
    logic                           irq_en_q, irq_en_d;
    logic [7:0]                     start_cnt_q, start_cnt_d;
    logic                           done_sticky_q, done_sticky_d;
    logic                           start_rej_q, start_rej_d;
    logic                           done_prev_q, done_prev_d;
    logic                           irq_q, irq_d;
    logic [DATA_W-1:0]              perf_val;

    logic                           busy_int;
    logic                           done_edge;
    logic                           accept;
    logic                           wr;
    logic                           ctrl_wr;
    logic                           status_wr;
    logic                           start_go;
    logic                           start_bad;
    logic                           addr_mapped;
    logic [N_CFG-1:0]               cfg_hit;
    logic [DATA_W-1:0]              rd_data;

    assign busy_int  = core_busy | (start_cnt_q != 8'd0);
    assign done_edge = core_done & ~done_prev_q;
    assign accept    = (state_q == S_IDLE) & req_valid;
    assign wr        = accept & req_write;
    assign ctrl_wr   = wr & (req_addr == A_CTRL);
    assign status_wr = wr & (req_addr == A_STATUS);
    assign start_go  = ctrl_wr & req_wdata[0] & ~busy_int;
    assign start_bad = ctrl_wr & req_wdata[0] & busy_int;

`ifdef DSA_CSR_PERF_EN
    logic [DATA_W-1:0] perf_q, perf_d;

    assign perf_val = perf_q;

    always_comb begin
        perf_d = perf_q;
        if (start_go) begin
            perf_d = '0;
        end else if (core_busy && (perf_q != {DATA_W{1'b1}})) begin
            perf_d = perf_q + DATA_W'(1);
        end
    end
`else
    assign perf_val = '0;
`endif

    // Read data reflects register state before any same-cycle update.
    always_comb begin
        rd_data     = '0;
        addr_mapped = 1'b1;
        cfg_hit     = '0;
        if (req_addr == A_CTRL) begin
            rd_data[1] = irq_en_q;
        end else if (req_addr == A_STATUS) begin
            rd_data[2:0] = {busy_int, start_rej_q, done_sticky_q};
        end else if (req_addr == A_PERF) begin
            rd_data = perf_val;
        end else begin
            for (int k = 0; k < N_CFG; k++) begin
                if (req_addr == ADDR_W'(k + 1)) begin
                    cfg_hit[k] = 1'b1;
                    rd_data    = cfg_q[k];
                end
            end
            if (cfg_hit == '0) begin
                addr_mapped = 1'b0;
                rd_data     = BAD_DATA;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = accept;
        rsp_rdata_d = (accept && !req_write) ? rd_data : '0;
        rsp_err_d   = accept & (~addr_mapped | start_bad);

        irq_en_d = ctrl_wr ? req_wdata[1] : irq_en_q;

        cfg_d = cfg_q;
        for (int k = 0; k < N_CFG; k++) begin
            if (wr && cfg_hit[k]) cfg_d[k] = req_wdata;
        end

        if (start_go) begin
            start_cnt_d = START_LD;
        end else if (start_cnt_q != 8'd0) begin
            start_cnt_d = start_cnt_q - 8'd1;
        end else begin
            start_cnt_d = 8'd0;
        end

        // A hardware set in the same cycle as a W1C clear wins.
        done_sticky_d = (done_sticky_q & ~(status_wr & req_wdata[0])) | done_edge;
        start_rej_d   = (start_rej_q & ~(status_wr & req_wdata[1])) | start_bad;
        done_prev_d   = core_done;
        irq_d         = irq_en_q & done_sticky_q;
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            state_q       <= S_IDLE;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            cfg_q         <= CFG_RST_VAL;
            irq_en_q      <= 1'b0;
            start_cnt_q   <= 8'd0;
            done_sticky_q <= 1'b0;
            start_rej_q   <= 1'b0;
            done_prev_q   <= 1'b0;
            irq_q         <= 1'b0;
`ifdef DSA_CSR_PERF_EN
            perf_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            cfg_q         <= cfg_d;
            irq_en_q      <= irq_en_d;
            start_cnt_q   <= start_cnt_d;
            done_sticky_q <= done_sticky_d;
            start_rej_q   <= start_rej_d;
            done_prev_q   <= done_prev_d;
            irq_q         <= irq_d;
`ifdef DSA_CSR_PERF_EN
            perf_q        <= perf_d;
`endif
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign cfg_flat    = cfg_q;
    assign start_pulse = (start_cnt_q != 8'd0);
    assign irq         = irq_q;

endmodule
